// File: rtl/expr_vector_sequencer_if.sv
// Signal bundle between test controller, vector sequencer and expression block.
// Golden-compare signals exist only when EXPR_SEQ_GOLDEN_CMP_EN is defined.
interface expr_vector_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [59:0]      seed;
  logic [CNT_W-1:0] num_vectors;
  logic [3:0]       a0;
  logic [4:0]       a1;
  logic [5:0]       a2;
  logic [3:0]       a3;
  logic [4:0]       a4;
  logic [5:0]       a5;
  logic [3:0]       b0;
  logic [4:0]       b1;
  logic [5:0]       b2;
  logic [3:0]       b3;
  logic [4:0]       b4;
  logic [5:0]       b5;
  logic [89:0]      y_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_count;
  logic [89:0]      signature;
`ifdef EXPR_SEQ_GOLDEN_CMP_EN
  logic [89:0]      golden_sig;
  logic             pass;
  logic             fail;
`endif

  modport master (
    input  start, abort, seed, num_vectors, y_in,
    output a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5,
    output busy, done, vec_count, signature
`ifdef EXPR_SEQ_GOLDEN_CMP_EN
    , input golden_sig
    , output pass, fail
`endif
  );

  modport slave (
    output start, abort, seed, num_vectors, y_in,
    input  a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5,
    input  busy, done, vec_count, signature
`ifdef EXPR_SEQ_GOLDEN_CMP_EN
    , output golden_sig
    , input pass, fail
`endif
  );
endinterface

// File: rtl/expr_vector_sequencer.sv
// LFSR-driven operand sequencer folding expression results into a 90-bit MISR.
// Optional golden signature compare enabled by EXPR_SEQ_GOLDEN_CMP_EN.
module expr_vector_sequencer #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  expr_vector_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPTURE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t           state_reg, state_next;
  logic [59:0]      lfsr_reg;
  logic [59:0]      ops_reg;
  logic [89:0]      sig_reg;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       wait_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic             fb;

  assign cnt_inc = cnt_reg + 1'b1;
  assign fb      = sig_reg[89] ^ sig_reg[88] ^ sig_reg[87] ^ sig_reg[84];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.abort)      state_next = IDLE;
        else if (bus.start) state_next = (bus.num_vectors == '0) ? DONE : DRIVE;
      end
      DRIVE: begin
        if (bus.abort)        state_next = IDLE;
        else if (SETTLE == 0) state_next = CAPTURE;
        else                  state_next = WAIT;
      end
      WAIT: begin
        if (bus.abort)                    state_next = IDLE;
        else if (wait_reg == SETTLE_LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (bus.abort)             state_next = IDLE;
        else if (cnt_inc == num_reg) state_next = DONE;
        else                         state_next = DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An abort edge leaves every datapath register untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_reg <= '0;
      ops_reg  <= '0;
      sig_reg  <= '0;
      num_reg  <= '0;
      cnt_reg  <= '0;
      wait_reg <= '0;
    end else if (!bus.abort) begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            lfsr_reg <= (bus.seed == '0) ? 60'd1 : bus.seed;
            num_reg  <= bus.num_vectors;
            sig_reg  <= '0;
            cnt_reg  <= '0;
          end
        end
        DRIVE: begin
          ops_reg  <= lfsr_reg;
          wait_reg <= '0;
        end
        WAIT: wait_reg <= wait_reg + 4'd1;
        CAPTURE: begin
          sig_reg  <= {sig_reg[88:0], fb} ^ bus.y_in;
          lfsr_reg <= {lfsr_reg[58:0], lfsr_reg[59] ^ lfsr_reg[58]};
          cnt_reg  <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.a0 = ops_reg[59:56];
  assign bus.a1 = ops_reg[55:51];
  assign bus.a2 = ops_reg[50:45];
  assign bus.a3 = ops_reg[44:41];
  assign bus.a4 = ops_reg[40:36];
  assign bus.a5 = ops_reg[35:30];
  assign bus.b0 = ops_reg[29:26];
  assign bus.b1 = ops_reg[25:21];
  assign bus.b2 = ops_reg[20:15];
  assign bus.b3 = ops_reg[14:11];
  assign bus.b4 = ops_reg[10:6];
  assign bus.b5 = ops_reg[5:0];

  assign bus.busy      = (state_reg == DRIVE) || (state_reg == WAIT) || (state_reg == CAPTURE);
  assign bus.done      = (state_reg == DONE);
  assign bus.vec_count = cnt_reg;
  assign bus.signature = sig_reg;

`ifdef EXPR_SEQ_GOLDEN_CMP_EN
  assign bus.pass = (state_reg == DONE) && (sig_reg == bus.golden_sig);
  assign bus.fail = (state_reg == DONE) && (sig_reg != bus.golden_sig);
`endif
endmodule

// File: doc/expr_vector_sequencer.md
Name: expr_vector_sequencer

Overview:
- Self-checking stimulus sequencer for one combinational expression block (12 operand inputs a0..a5/b0..b5, 90-bit result y).
- Drives pseudo-random operands from a 60-bit LFSR and waits a programmable settle time.
- Folds each 90-bit result into a MISR signature, then reports done.
- Sits in the regression harness between the test controller and the expression block under test.

Parameters:
SETTLE, 1, wait cycles between operand update and result capture (0..15)
CNT_W, 16, width of vector counter and num_vectors

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
start  in  1  begin run; sampled only in IDLE/DONE
abort  in  1  stop run, return to IDLE
seed  in  60  LFSR seed captured on start; 0 replaced by 1
num_vectors  in  CNT_W  vectors per run, captured on start
a0 a1 a2 a3 a4 a5  out  4,5,6,4,5,6  operands A (a3..a5 consumed as signed)
b0 b1 b2 b3 b4 b5  out  4,5,6,4,5,6  operands B (b3..b5 consumed as signed)
y_in  in  90  result of expression block
busy  out  1  high in DRIVE/WAIT/CAPTURE
done  out  1  high in DONE
vec_count  out  CNT_W  vectors captured this run
signature  out  90  MISR value

Behaviour:
- Reset: state IDLE; all operands, lfsr, signature, vec_count 0; busy=0, done=0.
- States: IDLE, DRIVE, WAIT, CAPTURE, DONE.
- IDLE/DONE + start:
  - lfsr<=(seed==0)?1:seed; latch num_vectors; signature<=0; vec_count<=0.
  - Next state DRIVE, or DONE if num_vectors==0.
- DRIVE (1 cycle): operands load from lfsr.
  - Mapping: a0=[59:56] a1=[55:51] a2=[50:45] a3=[44:41] a4=[40:36] a5=[35:30] b0=[29:26] b1=[25:21] b2=[20:15] b3=[14:11] b4=[10:6] b5=[5:0].
  - Next state WAIT, or CAPTURE if SETTLE==0.
- WAIT: internal counter runs SETTLE cycles; operands held stable.
- CAPTURE (1 cycle):
  - signature<={signature[88:0], fb}^y_in, where fb=signature[89]^signature[88]^signature[87]^signature[84].
  - lfsr<={lfsr[58:0], lfsr[59]^lfsr[58]}.
  - vec_count++.
  - If new vec_count==latched num_vectors, next state DONE; else DRIVE.
- Per-vector latency: 2+SETTLE cycles. done rises N*(2+SETTLE) cycles after the start-sampling edge.
- DONE holds done=1 and all outputs until start (new run) or abort (to IDLE, done cleared).
- abort in DRIVE/WAIT/CAPTURE:
  - Next state IDLE; no capture on that edge.
  - signature, vec_count and operands keep their last values; done stays 0.
- abort has priority over start. start while busy is ignored.
- vec_count does not wrap: the maximum num_vectors is 2^CNT_W-1.
- Asynchronous reset mid-run returns to the reset values immediately.

Optional Feature:
- Macro: EXPR_SEQ_GOLDEN_CMP_EN.
- Defined:
  - Adds input golden_sig[89:0] and outputs pass, fail (1 bit each).
  - In DONE: pass=(signature==golden_sig), fail=!pass.
  - Both are 0 in all other states and at reset; compare is combinational on the registered signature.
- Undefined: those ports do not exist; behaviour is otherwise identical.

Test Plan:
- SETTLE=1, seed=1, num_vectors=1, y_in=0 -> after DRIVE b5=1, all other operands 0; done rises 3 cycles after start edge; signature=0, vec_count=1.
- seed=0, num_vectors=2, y_in=0 -> first vector b5=1, second b5=2 (zero-seed substitution and LFSR step).
- y_in held at 90'd1, num_vectors=2 -> signature=1 after first CAPTURE, 90'd3 at done.
- num_vectors=0, start -> DONE on next edge; busy never asserted; signature=0; operands unchanged.
- num_vectors=10, abort asserted during WAIT of vector 4 -> IDLE next edge; vec_count=3; done=0. A subsequent start restarts from the new seed with signature cleared.
- EXPR_SEQ_GOLDEN_CMP_EN with golden_sig=90'd3 and the y_in=1/N=2 run -> pass=1 in DONE. With golden_sig=90'd2 -> fail=1. Reset during DONE -> pass=fail=0.
